// File: rtl/l1c_axi_arbiter.sv
// l1c_axi_arbiter: shares one AXI master between the L1 I-cache and D-cache.
// Optional build macro ARB_RR_EN selects round-robin instead of fixed D > I priority.
module l1c_axi_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                I_req,
    input  logic [ADDR_W-1:0]   I_addr,
    output logic                I_wait,
    output logic [DATA_W-1:0]   I_out,
    input  logic                D_req,
    input  logic [ADDR_W-1:0]   D_addr,
    input  logic                D_write,
    input  logic [DATA_W-1:0]   D_in,
    input  logic [2:0]          D_type,
    output logic                D_wait,
    output logic [DATA_W-1:0]   D_out,
    output logic [3:0]          ARID,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [3:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [3:0]          RID,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY,
    output logic [3:0]          AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [3:0]          BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic                grant_d
);

    typedef enum logic [2:0] {
        IDLE, RD_AR, RD_R, WR_AWW, WR_B
    } state_t;

    state_t              state, nxt;
    logic                own_d;
    logic                wr;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [2:0]          dtype;
    logic                aw_done, w_done;
    logic                pick_d;
    logic                any_req;
    logic [DATA_W/8-1:0] strb;

    // Response IDs/status and the signedness bit of D_type carry no meaning here
    logic unused_in;
    assign unused_in = ^{RID, RRESP, BID, BRESP, dtype[2]};

    assign any_req = I_req | D_req;
    assign grant_d = own_d;

`ifdef ARB_RR_EN
    logic last_d;

    // Remember the previous owner so a tie goes to the other cache
    always_ff @(posedge clk) begin
        if (rst)
            last_d <= 1'b1;
        else if (state == IDLE && any_req)
            last_d <= pick_d;
    end

    assign pick_d = D_req & (~I_req | ~last_d);
`else
    assign pick_d = D_req;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Capture the winning request when a transaction is launched from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            own_d <= 1'b0;
            wr    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            dtype <= '0;
        end else if (state == IDLE && any_req) begin
            own_d <= pick_d;
            wr    <= pick_d & D_write;
            addr  <= pick_d ? D_addr : I_addr;
            wdata <= D_in;
            dtype <= D_type;
        end
    end

    // Track AW and W handshakes independently while both channels are open
    always_ff @(posedge clk) begin
        if (rst || state != WR_AWW) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (AWVALID && AWREADY) aw_done <= 1'b1;
            if (WVALID && WREADY)   w_done  <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:   if (any_req)
                        nxt = (pick_d && D_write) ? WR_AWW : RD_AR;
            RD_AR:  if (ARREADY) nxt = RD_R;
            RD_R:   if (RVALID && RLAST) nxt = IDLE;
            WR_AWW: if ((aw_done || AWREADY) && (w_done || WREADY))
                        nxt = WR_B;
            WR_B:   if (BVALID) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Active-low byte strobes from access size and address offset
    always_comb begin
        strb = '1;
        unique case (dtype[1:0])
            2'b00: strb[addr[1:0]] = 1'b0;
            2'b01: if (!addr[0]) strb[{addr[1], 1'b0} +: 2] = 2'b00;
            default: strb = '0;
        endcase
    end

    // AXI channel and cache-side outputs
    always_comb begin
        ARID    = {3'b000, own_d};
        ARADDR  = addr;
        ARLEN   = 4'(BURST_LEN - 1);
        ARSIZE  = 3'd0;
        ARBURST = 2'd1;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        AWID    = {3'b000, own_d};
        AWADDR  = addr;
        AWLEN   = 4'd0;
        AWSIZE  = 3'd0;
        AWBURST = 2'd1;
        AWVALID = 1'b0;
        WDATA   = wdata;
        WSTRB   = strb;
        WLAST   = 1'b1;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        I_wait  = 1'b1;
        D_wait  = 1'b1;
        I_out   = RDATA;
        D_out   = RDATA;
        unique case (state)
            RD_AR:  ARVALID = 1'b1;
            RD_R: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    I_wait = own_d;
                    D_wait = ~own_d;
                end
            end
            WR_AWW: begin
                AWVALID = ~aw_done;
                WVALID  = ~w_done;
            end
            WR_B: begin
                BREADY = 1'b1;
                D_wait = ~BVALID;
            end
            default: ;
        endcase
    end

    logic unused_wr;
    assign unused_wr = wr;

endmodule

// File: tb/tb_l1c_axi_arbiter.sv
// tb_l1c_axi_arbiter: directed AXI slave stimulus with a queue-based scoreboard.
// Expectations are pushed by the stimulus tasks and popped by a negedge monitor.
module tb_l1c_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        I_req = 0, D_req = 0, D_write = 0;
    logic [31:0] I_addr = 0, D_addr = 0, D_in = 0;
    logic [2:0]  D_type = 0;
    logic        I_wait, D_wait, grant_d;
    logic [31:0] I_out, D_out;
    logic [3:0]  ARID, ARLEN, AWID, AWLEN;
    logic [31:0] ARADDR, AWADDR, WDATA;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;
    logic        ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY;
    logic [3:0]  WSTRB;
    logic        ARREADY = 0, AWREADY = 0, WREADY = 0, BVALID = 0;
    logic        RVALID = 0, RLAST = 0;
    logic [31:0] RDATA = 0;

    always #5 clk = ~clk;

    l1c_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .I_req(I_req), .I_addr(I_addr), .I_wait(I_wait), .I_out(I_out),
        .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in),
        .D_type(D_type), .D_wait(D_wait), .D_out(D_out),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(4'd0), .RDATA(RDATA), .RRESP(2'd0), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY), .BID(4'd0), .BRESP(2'd0), .BVALID(BVALID),
        .BREADY(BREADY), .grant_d(grant_d)
    );

    localparam logic [2:0] T_BYTE = 3'd0, T_HWORD = 3'd1, T_WORD = 3'd2;

    typedef struct packed {
        logic        d;
        logic [31:0] data;
    } r_e;

    logic [35:0] ar_q[$];
    r_e          r_q[$];
    logic [35:0] aw_q[$];
    logic [36:0] w_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        aw_seen = 0, w_seen = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare every handshake and the wait lines each cycle
    always @(negedge clk) begin : mon
        logic        exp_i, exp_d;
        logic [35:0] e;
        logic [36:0] we;
        r_e          re;
        if (!rst) begin
            exp_i = 1'b1;
            exp_d = 1'b1;
            if (ARVALID && ARREADY) begin
                if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
                else begin
                    e = ar_q.pop_front();
                    check("ar_fields", {ARID, ARADDR, ARLEN, ARSIZE, ARBURST},
                          {e[35:32], e[31:0], 4'd3, 3'd0, 2'd1});
                    check("grant_d", grant_d, e[32]);
                end
            end
            if (RVALID && RREADY) begin
                if (r_q.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    re = r_q.pop_front();
                    if (re.d) exp_d = 1'b0;
                    else      exp_i = 1'b0;
                    check("r_data", re.d ? D_out : I_out, re.data);
                end
            end
            if (AWVALID && AWREADY) begin
                aw_seen = 1'b1;
                if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
                else begin
                    e = aw_q.pop_front();
                    check("aw_fields", {AWID, AWADDR, AWLEN, AWBURST},
                          {e, 4'd0, 2'd1});
                end
            end
            if (WVALID && WREADY) begin
                w_seen = 1'b1;
                if (w_q.size() == 0) check("w_unexpected", 1, 0);
                else begin
                    we = w_q.pop_front();
                    check("w_fields", {WSTRB, WLAST, WDATA}, we);
                end
            end
            if (BREADY) check("b_after_aw_w", {aw_seen, w_seen}, 2'b11);
            if (BVALID && BREADY) begin
                exp_d   = 1'b0;
                aw_seen = 1'b0;
                w_seen  = 1'b0;
            end
            check("I_wait", I_wait, exp_i);
            check("D_wait", D_wait, exp_d);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int which, input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            ok = (which == 0) ? ARVALID : (which == 1) ? AWVALID : BREADY;
        end
        if (!ok) check({"timeout_", name}, 0, 1);
    endtask

    task automatic do_read(input bit d, input logic [31:0] a,
                           input logic [31:0] dbase, input int ar_dly,
                           input int gap_at, input int abort_at);
        bit ok;
        ar_q.push_back({3'b000, d, a});
        wait_for(0, "arvalid", ok);
        if (!ok) return;
        repeat (ar_dly) step();
        ARREADY = 1;
        step();
        ARREADY = 0;
        for (int b = 0; b < 4; b++) begin
            if (b == abort_at) begin
                rst = 1; RVALID = 0; RLAST = 0; I_req = 0; D_req = 0;
                step();
                check("rst_rready", RREADY, 0);
                check("rst_arvalid", ARVALID, 0);
                check("rst_iwait", I_wait, 1);
                check("rst_grant_d", grant_d, 0);
                rst = 0;
                return;
            end
            if (b == gap_at) begin
                RVALID = 0;
                step();
            end
            r_q.push_back('{d, dbase + 32'(b)});
            RDATA  = dbase + 32'(b);
            RLAST  = (b == 3);
            RVALID = 1;
            step();
        end
        RVALID = 0;
        RLAST  = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] data,
                            input logic [2:0] ty, input int aw_dly,
                            input int w_dly, input logic [3:0] strb);
        bit ok;
        D_req = 1; D_write = 1; D_addr = a; D_in = data; D_type = ty;
        aw_q.push_back({4'd1, a});
        w_q.push_back({strb, 1'b1, data});
        wait_for(1, "awvalid", ok);
        if (ok) begin
            for (int c = 0; c <= (aw_dly > w_dly ? aw_dly : w_dly); c++) begin
                AWREADY = (c == aw_dly);
                WREADY  = (c == w_dly);
                step();
            end
            AWREADY = 0;
            WREADY  = 0;
            wait_for(2, "bready", ok);
            if (ok) begin
                BVALID = 1;
                step();
                BVALID = 0;
            end
        end
        D_req = 0; D_write = 0;
        repeat (2) step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 0);
        check("rst_waits", {I_wait, D_wait}, 2'b11);
        check("rst_grant", grant_d, 0);
        rst = 0;
        repeat (2) step();

        I_req = 1; I_addr = 32'h100;
        do_read(0, 32'h100, 32'h1111_0000, 2, -1, -1);
        I_req = 0;
        repeat (3) step();

        D_req = 1; D_write = 0; D_addr = 32'h2000;
        do_read(1, 32'h2000, 32'h2222_0000, 0, 2, -1);
        D_req = 0;
        repeat (3) step();

        do_write(32'h2003, 32'h0000_00AA, T_BYTE, 3, 0, 4'b0111);
        do_write(32'h3000, 32'h1234_5678, T_WORD, 0, 0, 4'b0000);
        do_write(32'h1002, 32'hBEEF_0000, T_HWORD, 0, 2, 4'b0011);
        do_write(32'h1001, 32'h0000_BEEF, T_HWORD, 1, 1, 4'b1111);
        do_write(32'h2001, 32'h0000_5500, T_BYTE, 0, 1, 4'b1101);

        I_req = 1; I_addr = 32'h400;
        D_req = 1; D_write = 0; D_addr = 32'h500;
        do_read(1, 32'h500, 32'h5000_0000, 0, -1, -1);
        do_read(1, 32'h500, 32'h5100_0000, 1, -1, -1);
        do_read(1, 32'h500, 32'h5200_0000, 0, -1, -1);
        D_req = 0;
        do_read(0, 32'h400, 32'h4000_0000, 0, -1, -1);
        I_req = 0;
        repeat (3) step();

        I_req = 1; I_addr = 32'h600;
        do_read(0, 32'h600, 32'h6000_0000, 0, -1, 2);
        step();
        I_req = 1; I_addr = 32'h700;
        do_read(0, 32'h700, 32'h7000_0000, 1, 1, -1);
        I_req = 0;
        repeat (4) step();

        check("ar_q_empty", ar_q.size(), 0);
        check("r_q_empty", r_q.size(), 0);
        check("aw_q_empty", aw_q.size(), 0);
        check("w_q_empty", w_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
